// File: rtl/spi_slave_gen2_pkg.sv
// Shared register map, control/status bit positions, FSM states and helpers
// for the oversampling Wishbone SPI slave.
package spi_slave_gen2_pkg;

  // Register select values on wb_adr_i[4:2]
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // CTRL bit positions ([5:0] is CHAR_LEN)
  localparam int CTRL_LEN_W  = 6;
  localparam int CTRL_RX_NEG = 8;
  localparam int CTRL_TX_NEG = 9;
  localparam int CTRL_LSB    = 10;
  localparam int CTRL_IE     = 11;
  localparam int CTRL_EN     = 12;

  // STATUS bit positions
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_BUSY     = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_e;

  typedef struct packed {
    logic                  en;
    logic                  ie;
    logic                  lsb;
    logic                  tx_neg;
    logic                  rx_neg;
    logic [CTRL_LEN_W-1:0] char_len;
  } ctrl_t;

  // CHAR_LEN of 0 (or anything beyond the data width) means a full-width character.
  function automatic logic [CTRL_LEN_W-1:0] eff_char_len(input logic [CTRL_LEN_W-1:0] len,
                                                         input int max_len);
    if (len == '0 || int'(len) > max_len) return CTRL_LEN_W'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/spi_slave_gen2_sync_edge.sv
// Multi-stage synchroniser for one SPI pad with registered rise/fall strobes.
// Level output lags the pad by STAGES cycles, the edge strobes by STAGES+1.
module spi_slave_gen2_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  // Synchroniser chain, previous-value flop and edge strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_gen2.sv
// Wishbone SPI slave that oversamples the SPI pads in the wb_clk_i domain.
// Programmable character length, edge selection, bit order, a one-deep TX
// buffer and an RX holding register with overrun detection.
module spi_slave_gen2
  import spi_slave_gen2_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SS_NB       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_int_o,
  input  logic [SS_NB-1:0] ss_pad_i,
  input  logic             sclk_pad_i,
  input  logic             mosi_pad_i,
  output logic             miso_pad_o
);

  // Pad synchronisers
  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_all_s, ss_rise_unused, ss_fall_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic sel_s;

  spi_slave_gen2_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i (wb_clk_i), .rst_i (wb_rst_i), .d_i (sclk_pad_i),
    .q_o (sclk_s), .rise_o (sclk_rise), .fall_o (sclk_fall)
  );

  spi_slave_gen2_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk_i (wb_clk_i), .rst_i (wb_rst_i), .d_i (&ss_pad_i),
    .q_o (ss_all_s), .rise_o (ss_rise_unused), .fall_o (ss_fall_unused)
  );

  spi_slave_gen2_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i (wb_clk_i), .rst_i (wb_rst_i), .d_i (mosi_pad_i),
    .q_o (mosi_s), .rise_o (mosi_rise_unused), .fall_o (mosi_fall_unused)
  );

  assign sel_s = ~ss_all_s;

  // Registers
  ctrl_t             ctrl_q;
  logic [DATA_W-1:0] tx_buf_q, rx_q, shift_q, shift_d;
  logic              tx_empty_q, rx_valid_q, ovr_q, busy_q, busy_d;
  logic              miso_q, miso_d;
  logic              sampled_q, sampled_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              ack_q, int_q;
  logic [31:0]       dat_q, rdata;
  state_e            state_q, state_d;

  // Bus decode
  logic       wb_req, wr_hit, rd_hit;
  logic [2:0] reg_sel;
  logic       sclk_level_unused;
  logic       bus_bits_unused;

  assign wb_req  = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_hit  = wb_req & wb_we_i;
  assign rd_hit  = wb_req & ~wb_we_i;
  assign reg_sel = wb_adr_i[4:2];
  assign sclk_level_unused = sclk_s;
  assign bus_bits_unused   = ^{wb_adr_i[1:0], wb_dat_i, wb_sel_i};

  // Character geometry derived from CTRL
  logic [5:0]        len, len_m1;
  logic [DATA_W-1:0] len_mask, load_word, load_msb, cur_msb, rx_new;
  logic              sample_edge, launch_edge;
  logic              do_load, rx_upd;

  assign len         = eff_char_len(ctrl_q.char_len, DATA_W);
  assign len_m1      = len - 6'd1;
  assign sample_edge = ctrl_q.rx_neg ? sclk_fall : sclk_rise;
  assign launch_edge = ctrl_q.tx_neg ? sclk_fall : sclk_rise;
  assign load_word   = tx_empty_q ? '0 : (tx_buf_q & len_mask);
  assign load_msb    = load_word >> len_m1;
  assign cur_msb     = shift_q >> len_m1;
  assign rx_new      = shift_d & len_mask;

  // Mask of the active character bits.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < DATA_W; i++) len_mask[i] = (i < int'(len));
  end

  // FSM state and shift datapath registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      sampled_q <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      sampled_q <= sampled_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
    end
  end

  // FSM next state, shifting and character completion.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    sampled_d = sampled_q;
    miso_d    = miso_q;
    busy_d    = busy_q;
    do_load   = 1'b0;
    rx_upd    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (ctrl_q.en && sel_s) state_d = S_LOAD;
      end
      S_LOAD: begin
        do_load   = 1'b1;
        shift_d   = load_word;
        miso_d    = ctrl_q.lsb ? load_word[0] : load_msb[0];
        cnt_d     = '0;
        sampled_d = 1'b0;
        busy_d    = 1'b1;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (!sel_s) begin
          // Partial character is dropped; miso keeps its last value.
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          // The first launch edge precedes any sample and would skip bit 0.
          if (launch_edge && sampled_q) miso_d = ctrl_q.lsb ? shift_q[0] : cur_msb[0];
          if (sample_edge) begin
            if (ctrl_q.lsb) shift_d = (shift_q >> 1) | (DATA_W'(mosi_s) << len_m1);
            else            shift_d = (shift_q << 1) | DATA_W'(mosi_s);
            cnt_d     = cnt_q + 6'd1;
            sampled_d = 1'b1;
            if (cnt_d == len) begin
              rx_upd  = 1'b1;
              state_d = S_LOAD;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file: CTRL, TX buffer, RX holding register and status flags.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q     <= '0;
      tx_buf_q   <= '0;
      tx_empty_q <= 1'b1;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (wr_hit && reg_sel == REG_CTRL && !busy_q) begin
        if (wb_sel_i[0]) ctrl_q.char_len <= wb_dat_i[CTRL_LEN_W-1:0];
        if (wb_sel_i[1]) begin
          ctrl_q.rx_neg <= wb_dat_i[CTRL_RX_NEG];
          ctrl_q.tx_neg <= wb_dat_i[CTRL_TX_NEG];
          ctrl_q.lsb    <= wb_dat_i[CTRL_LSB];
          ctrl_q.ie     <= wb_dat_i[CTRL_IE];
          ctrl_q.en     <= wb_dat_i[CTRL_EN];
        end
      end
      // A write landing with LOAD wins: LOAD already took the old buffer.
      if (wr_hit && reg_sel == REG_DATA) begin
        tx_buf_q   <= wb_dat_i[DATA_W-1:0];
        tx_empty_q <= 1'b0;
      end else if (do_load) begin
        tx_empty_q <= 1'b1;
      end
      // A new character beats a simultaneous DATA read.
      if (rx_upd) begin
        rx_q       <= rx_new;
        rx_valid_q <= 1'b1;
      end else if (rd_hit && reg_sel == REG_DATA) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_upd && rx_valid_q) ovr_q <= 1'b1;
      else if (wr_hit && reg_sel == REG_STATUS && wb_sel_i[0] && wb_dat_i[STAT_OVERRUN])
        ovr_q <= 1'b0;
    end
  end

  // Read data multiplexer.
  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_DATA: rdata = 32'(rx_q);
      REG_CTRL: begin
        rdata[CTRL_LEN_W-1:0] = ctrl_q.char_len;
        rdata[CTRL_RX_NEG]    = ctrl_q.rx_neg;
        rdata[CTRL_TX_NEG]    = ctrl_q.tx_neg;
        rdata[CTRL_LSB]       = ctrl_q.lsb;
        rdata[CTRL_IE]        = ctrl_q.ie;
        rdata[CTRL_EN]        = ctrl_q.en;
      end
      REG_STATUS: begin
        rdata[STAT_RX_VALID] = rx_valid_q;
        rdata[STAT_TX_EMPTY] = tx_empty_q;
        rdata[STAT_OVERRUN]  = ovr_q;
        rdata[STAT_BUSY]     = busy_q;
      end
      default: rdata = '0;
    endcase
  end

  // Bus handshake, registered read data and interrupt.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      int_q <= 1'b0;
    end else begin
      ack_q <= wb_req;
      if (rd_hit) dat_q <= rdata;
      int_q <= ctrl_q.ie & (rx_valid_q | ovr_q);
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_err_o   = 1'b0;
  assign wb_int_o   = int_q;
  assign miso_pad_o = miso_q;

endmodule
